// File: rtl/arith_pkg.sv
// Shared types and constants for the nibble-serial arithmetic units.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE = 4;

  // Width of the slice index counter: clog2(nslice), never less than one bit.
  function automatic int idx_width(input int nslice);
    return (nslice <= 1) ? 1 : $clog2(nslice);
  endfunction

endpackage

// File: rtl/la_sub4.sv
// 4-bit lookahead subtract slice: x - y - bin, computed as x + ~y + ~bin.
module la_sub4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout,
  output logic       b3
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p    = x ^ ~y;
  assign g    = x & ~y;
  assign c[0] = ~bin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

  // A carry out of the add form is the absence of a borrow.
  assign d    = p ^ c[3:0];
  assign bout = ~c[4];
  assign b3   = ~c[3];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor, diff = a - b - bin, one nibble per cycle through la_sub4.
// Define NIBBLE_SUB_SAT_EN to saturate diff on signed overflow.
module nibble_serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / NIBBLE;
  localparam int IW     = idx_width(NSLICE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  if (WIDTH < NIBBLE || (WIDTH % NIBBLE) != 0) begin : g_bad_width
    $error("nibble_serial_subtractor: WIDTH must be a positive multiple of 4");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, diff_q;
  logic [IW-1:0]    idx_q;
  logic             borrow_q, out_valid_q, bout_q, ovf_q, zero_q;

  logic [NIBBLE-1:0] nib;
  logic              slice_bout, slice_b3;
  logic [WIDTH-1:0]  acc_d, diff_d;
  logic              ovf_d, zero_d;

  // Operands shift right each RUN cycle, so the slice always sees the low nibble.
  la_sub4 u_slice (
    .x    (a_q[NIBBLE-1:0]),
    .y    (b_q[NIBBLE-1:0]),
    .bin  (borrow_q),
    .d    (nib),
    .bout (slice_bout),
    .b3   (slice_b3)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_d  = WIDTH'({nib, acc_q} >> NIBBLE);
    ovf_d  = slice_b3 ^ slice_bout;
    diff_d = acc_d;
`ifdef NIBBLE_SUB_SAT_EN
    if (ovf_d) begin
      diff_d = a_q[NIBBLE-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    zero_d = (diff_d == '0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      borrow_q    <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            idx_q    <= '0;
            acc_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_q      <= a_q >> NIBBLE;
          b_q      <= b_q >> NIBBLE;
          borrow_q <= slice_bout;
          acc_q    <= acc_d;
          idx_q    <= idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            diff_q      <= diff_d;
            bout_q      <= slice_bout;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Randomized and directed bench for nibble_serial_subtractor against an arithmetic model.
module tb_nibble_serial_subtractor;

  localparam int W  = 16;
  localparam int NS = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout, ovf, zero;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
  } res_t;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  // Reference from plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin);
    res_t   r;
    longint ua, ub, ubin, sa, sb, sd;
    ua   = longint'(xa);
    ub   = longint'(xb);
    ubin = longint'(xbin);
    r.diff = W'(ua - ub - ubin);
    r.bout = (ua < ub + ubin);
    sa = xa[W-1] ? ua - (longint'(1) << W) : ua;
    sb = xb[W-1] ? ub - (longint'(1) << W) : ub;
    sd = sa - sb - ubin;
    r.ovf = (sd > (longint'(1) << (W-1)) - 1) || (sd < -(longint'(1) << (W-1)));
`ifdef NIBBLE_SUB_SAT_EN
    if (r.ovf) r.diff = xa[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    r.zero = (r.diff == '0);
    return r;
  endfunction

  // One full transaction: accept, count edges to out_valid, sample, hand off.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                        output res_t obs, output int lat);
    @(negedge clk);
    a = xa; b = xb; bin = xbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    @(negedge clk);
    obs = {diff, bout, ovf, zero};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, diff, bout, ovf, zero} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, expected 0", {out_valid, diff, bout, ovf, zero});
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4] = '{16'h1234, 16'h0000, 16'h8000, 16'h5555};
    logic [W-1:0] vb [4] = '{16'h0234, 16'h0001, 16'h0000, 16'h5554};
    logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    res_t         ve [4];
    res_t         obs;
    int           lat;
    ve[0] = {16'h1000, 1'b0, 1'b0, 1'b0};
    ve[1] = {16'hFFFF, 1'b1, 1'b0, 1'b0};
`ifdef NIBBLE_SUB_SAT_EN
    ve[2] = {16'h8000, 1'b0, 1'b1, 1'b0};
`else
    ve[2] = {16'h7FFF, 1'b0, 1'b1, 1'b0};
`endif
    ve[3] = {16'h0000, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vc[i], obs, lat);
      n_vec++;
      if (obs !== ve[i]) begin
        n_err++;
        $display("FAIL directed_%0d: got diff/bout/ovf/zero %h, expected %h", i, obs, ve[i]);
      end
      n_vec++;
      if (lat !== NS) begin
        n_err++;
        $display("FAIL directed_latency_%0d: got %0d, expected %0d", i, lat, NS);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [W-1:0] xa, xb;
    logic         xbin;
    res_t         obs, exp_r;
    int           lat;
    for (int i = 0; i < 40; i++) begin
      xa   = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : W'($urandom);
      xb   = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : W'($urandom);
      xbin = 1'($urandom);
      exp_r = model(xa, xb, xbin);
      run_op(xa, xb, xbin, obs, lat);
      n_vec++;
      if (obs !== exp_r || lat !== NS) begin
        n_err++;
        $display("FAIL random_%0d a=%h b=%h bin=%b: got %h lat %0d, expected %h lat %0d",
                 i, xa, xb, xbin, obs, lat, exp_r, NS);
      end
    end
  endtask

  task automatic test_backpressure();
    res_t e1, e2;
    int   lat;
    e1 = model(16'h1234, 16'h0234, 1'b0);
    e2 = model(16'hAAAA, 16'h1111, 1'b0);
    @(negedge clk);
    a = 16'h1234; b = 16'h0234; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h1111;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if ({diff, bout, ovf, zero} !== e1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure_hold_%0d: got %h valid %b ready %b, expected %h valid 1 ready 0",
                 i, {diff, bout, ovf, zero}, out_valid, in_ready, e1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL backpressure_release: got valid/ready %b, expected 01", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL backpressure_capture: got in_ready %b, expected 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    @(negedge clk);
    n_vec++;
    if ({diff, bout, ovf, zero} !== e2 || lat !== NS) begin
      n_err++;
      $display("FAIL backpressure_second: got %h lat %0d, expected %h lat %0d",
               {diff, bout, ovf, zero}, lat, e2, NS);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    res_t obs, exp_r;
    int   lat;
    bit   seen;
    run_op(16'hFFFF, 16'h0001, 1'b0, obs, lat);
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, diff, bout, ovf, zero, in_ready} !== {1'b0, {W{1'b0}}, 3'b000, 1'b1}) begin
      n_err++;
      $display("FAIL reset_midrun_outputs: got %h, expected all zero with in_ready 1",
               {out_valid, diff, bout, ovf, zero, in_ready});
    end
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen |= out_valid;
    end
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= out_valid;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midrun_no_pulse: got out_valid pulse %b, expected 0", seen);
    end
    exp_r = {16'h000F, 1'b0, 1'b0, 1'b0};
    run_op(16'h0010, 16'h0001, 1'b0, obs, lat);
    n_vec++;
    if (obs !== exp_r || lat !== NS) begin
      n_err++;
      $display("FAIL reset_midrun_next: got %h lat %0d, expected %h lat %0d", obs, lat, exp_r, NS);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xa, xb;
    res_t         obs, exp_r;
    int           lat;
    for (int i = 0; i < 6; i++) begin
      xa = W'($urandom);
      xb = W'($urandom);
      exp_r = model(xa, xb, 1'b1);
      run_op(xa, xb, 1'b1, obs, lat);
      n_vec++;
      if (obs !== exp_r || lat !== NS || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL back_to_back_%0d: got %h lat %0d ready %b, expected %h lat %0d ready 1",
                 i, obs, lat, in_ready, exp_r, NS);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
Multi-cycle WIDTH-bit subtractor computing diff = a - b - bin, 4 bits per cycle.
- Uses one combinational 4-bit lookahead subtract slice; the borrow chain runs through a register between slices.
- Valid/ready handshake on both sides.
- Sits beside the lookahead adder family as the inverse arithmetic unit (subtract/compare path) for area-constrained datapaths.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4, minimum 4 (elaboration error otherwise)
NSLICE, WIDTH/4, derived local constant: cycles per operation

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands a, b, bin valid
in_ready  out  1  block can accept operands (high only in IDLE)
a  in  WIDTH  minuend
b  in  WIDTH  subtrahend
bin  in  1  borrow in
out_valid  out  1  result valid, held until accepted
out_ready  in  1  consumer accepts result
diff  out  WIDTH  a - b - bin, modulo 2^WIDTH
bout  out  1  final borrow: 1 iff unsigned a < b + bin
ovf  out  1  signed (two's complement) overflow of the subtraction
zero  out  1  diff == 0

Behaviour:
- Reset (async, any time):
  - state = IDLE; out_valid, diff, bout, ovf, zero = 0.
  - Internal operand, borrow and slice-index registers cleared.
  - in_ready = 1 after reset (decoded from IDLE); inputs are ignored while rst is high.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid at an edge: capture a, b; borrow_reg = bin; idx = 0; go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle slice idx computes nibble[idx] = a[4idx+3:4idx] + ~b[4idx+3:4idx] + ~borrow_reg.
  - Store the result into the diff accumulator; borrow_reg = ~carry_out; idx++.
  - On the edge that processes idx = NSLICE-1: go to DONE and register bout, ovf, zero.
- Latency: accept at edge T gives out_valid high after edge T+NSLICE (4 cycles at WIDTH=16).
- ovf: borrow into MSB XOR borrow out of MSB, taken from the last slice. This is correct including the bin=1 case.
- zero: evaluated on the full final diff (after saturation if enabled).
- DONE:
  - out_valid = 1; diff, bout, ovf, zero held stable.
  - in_ready = 0; new in_valid is ignored, and the upstream holds its operands.
  - On out_valid && out_ready: out_valid = 0, go to IDLE. The next accept is possible at the following edge, so there is one bubble per operation.
- Output registers are updated only on the DONE entry edge. They are not cleared on leaving DONE (values are stale but defined).
- Reset during RUN or DONE: the operation is abandoned, no out_valid pulse, and the next operation behaves as from power-up.
- WIDTH=4: a single RUN cycle. idx wrap is never reached because the transition to DONE occurs first.

Optional Feature:
Macro NIBBLE_SUB_SAT_EN.
- Defined: signed saturation. When ovf = 1, diff is forced to 0x7FF..F if a[MSB] = 0, or 0x800..0 if a[MSB] = 1. ovf and bout still report raw overflow and borrow.
- Undefined: diff wraps modulo 2^WIDTH, and no saturation logic is instantiated.

Decomposition:
- Package arith_pkg:
  - state enum (IDLE, RUN, DONE)
  - constant NIBBLE = 4
  - function computing the slice-index width, clog2(NSLICE), min 1
- Sub-module la_sub4, purely combinational: 4-bit lookahead subtract slice.
  - Inputs: 4-bit x, y, borrow in.
  - Outputs: 4-bit d, borrow out, borrow into bit 3.
  - Internally: P/G lookahead on x and ~y with carry-in = ~borrow.
- The top holds the FSM, index counter, operand/result registers and saturation.

Test Plan:
1. WIDTH=16: a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, ovf=0, zero=0; out_valid exactly 4 cycles after accept.
2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0, zero=0.
3. a=0x8000, b=0x0000, bin=1 -> diff=0x7FFF, ovf=1, bout=0; with NIBBLE_SUB_SAT_EN diff=0x8000, ovf=1.
4. a=0x5555, b=0x5554, bin=1 -> diff=0x0000, zero=1, bout=0, ovf=0.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with new operands -> outputs stable, in_ready=0, no capture. Raise out_ready -> IDLE, new operands accepted on the next edge.
6. Assert rst during RUN at idx=2 -> all outputs 0 immediately, out_valid never pulses; a following operation a=0x0010, b=0x0001 -> diff=0x000F.
